// File: rtl/tlb_mport_if.sv
// tlb_mport bus: lookup ports, tlbwi/tlbwr, tlbp, tlbr, wired/random.
// master = cp0/AGU side driving requests, slave = the TLB.
interface tlb_mport_if #(
  parameter int NUM_ENTRIES = 32,
  parameter int NUM_LKP     = 2
);
  localparam int IDX_W = $clog2(NUM_ENTRIES);

  logic [7:0]            cur_asid;
  logic [NUM_LKP-1:0]    lk_req;
  logic [NUM_LKP*19-1:0] lk_vpn2;
  logic [NUM_LKP-1:0]    lk_odd;
  logic [NUM_LKP-1:0]    lk_rvld;
  logic [NUM_LKP-1:0]    lk_hit;
  logic [NUM_LKP-1:0]    lk_v;
  logic [NUM_LKP-1:0]    lk_d;
  logic [NUM_LKP*3-1:0]  lk_c;
  logic [NUM_LKP*20-1:0] lk_pfn;

  logic             wr_en;
  logic             wr_random;
  logic [IDX_W-1:0] wr_index;
  logic [31:0]      wr_hi;
  logic [31:0]      wr_lo0;
  logic [31:0]      wr_lo1;
  logic             wr_done;

  logic             wired_we;
  logic [IDX_W-1:0] wired_val;
  logic [IDX_W-1:0] random_val;

  logic             p_req;
  logic             p_done;
  logic             p_miss;
  logic [IDX_W-1:0] p_index;

  logic             r_req;
  logic [IDX_W-1:0] r_index;
  logic             r_done;
  logic [31:0]      r_hi;
  logic [31:0]      r_lo0;
  logic [31:0]      r_lo1;

  modport master (
    output cur_asid, lk_req, lk_vpn2, lk_odd,
    output wr_en, wr_random, wr_index,
    output wr_hi, wr_lo0, wr_lo1,
    output wired_we, wired_val,
    output p_req, r_req, r_index,
    input  lk_rvld, lk_hit, lk_v, lk_d,
    input  lk_c, lk_pfn, wr_done,
    input  random_val, p_done, p_miss,
    input  p_index, r_done,
    input  r_hi, r_lo0, r_lo1
  );

  modport slave (
    input  cur_asid, lk_req, lk_vpn2, lk_odd,
    input  wr_en, wr_random, wr_index,
    input  wr_hi, wr_lo0, wr_lo1,
    input  wired_we, wired_val,
    input  p_req, r_req, r_index,
    output lk_rvld, lk_hit, lk_v, lk_d,
    output lk_c, lk_pfn, wr_done,
    output random_val, p_done, p_miss,
    output p_index, r_done,
    output r_hi, r_lo0, r_lo1
  );
endinterface

// File: rtl/tlb_mport.sv
// tlb_mport: NUM_ENTRIES-entry JTLB, NUM_LKP registered lookup ports,
// tlbwi/tlbwr write, tlbp probe, tlbr read, Wired/Random.
// Ports: clk, rst (sync, active-high), bus (tlb_mport_if.slave).
module tlb_mport #(
  parameter int NUM_ENTRIES = 32,
  parameter int NUM_LKP     = 2
) (
  input  logic       clk,
  input  logic       rst,
  tlb_mport_if.slave bus
);
  localparam int IDX_W = $clog2(NUM_ENTRIES);
  localparam logic [IDX_W-1:0] TOP = IDX_W'(NUM_ENTRIES - 1);

  typedef struct packed {
    logic [18:0] vpn2;
    logic [7:0]  asid;
    logic        g;
    logic [19:0] pfn0;
    logic [19:0] pfn1;
    logic [2:0]  c0;
    logic [2:0]  c1;
    logic        d0;
    logic        d1;
    logic        v0;
    logic        v1;
  } ent_t;

  // {hit, v, d, c[2:0], pfn[19:0]}
  typedef logic [25:0] res_t;

  ent_t             ent_q [NUM_ENTRIES];
  logic [IDX_W-1:0] wired_q;
  logic [IDX_W-1:0] random_q;
  logic [IDX_W-1:0] random_d;

  res_t             lk_res_d [NUM_LKP];
  res_t             lk_res_q [NUM_LKP];
  logic [NUM_LKP-1:0] lk_rvld_q;

  logic             p_hit_d;
  logic [IDX_W-1:0] p_idx_d;
  logic             p_done_q;
  logic             p_miss_q;
  logic [IDX_W-1:0] p_index_q;

  logic             r_done_q;
  logic [31:0]      r_hi_q;
  logic [31:0]      r_lo0_q;
  logic [31:0]      r_lo1_q;

  logic             wr_done_q;
  logic [IDX_W-1:0] wr_idx;
  ent_t             wr_ent;

  logic unused_ok;
  assign unused_ok = ^{bus.wr_hi[12:8],
                       bus.wr_lo0[31:26],
                       bus.wr_lo1[31:26]};

  // Scan high to low so the lowest matching index wins.
  always_comb begin
    for (int k = 0; k < NUM_LKP; k++) begin
      logic             hit;
      logic [IDX_W-1:0] idx;
      ent_t             e;
      hit = 1'b0;
      idx = '0;
      for (int i = NUM_ENTRIES - 1; i >= 0; i--) begin
        if (ent_q[i].vpn2 == bus.lk_vpn2[k*19 +: 19] &&
            (ent_q[i].g ||
             ent_q[i].asid == bus.cur_asid)) begin
          hit = 1'b1;
          idx = IDX_W'(i);
        end
      end
      e = ent_q[idx];
      lk_res_d[k] = '0;
      if (hit) begin
        lk_res_d[k] = bus.lk_odd[k] ?
          {1'b1, e.v1, e.d1, e.c1, e.pfn1} :
          {1'b1, e.v0, e.d0, e.c0, e.pfn0};
      end
    end
  end

  always_comb begin
    p_hit_d = 1'b0;
    p_idx_d = '0;
    for (int i = NUM_ENTRIES - 1; i >= 0; i--) begin
      if (ent_q[i].vpn2 == bus.wr_hi[31:13] &&
          (ent_q[i].g ||
           ent_q[i].asid == bus.wr_hi[7:0])) begin
        p_hit_d = 1'b1;
        p_idx_d = IDX_W'(i);
      end
    end
  end

  always_comb begin
    wr_idx      = bus.wr_random ? random_q : bus.wr_index;
    wr_ent.vpn2 = bus.wr_hi[31:13];
    wr_ent.asid = bus.wr_hi[7:0];
    wr_ent.g    = bus.wr_lo0[0] & bus.wr_lo1[0];
    wr_ent.pfn0 = bus.wr_lo0[25:6];
    wr_ent.pfn1 = bus.wr_lo1[25:6];
    wr_ent.c0   = bus.wr_lo0[5:3];
    wr_ent.c1   = bus.wr_lo1[5:3];
    wr_ent.d0   = bus.wr_lo0[2];
    wr_ent.d1   = bus.wr_lo1[2];
    wr_ent.v0   = bus.wr_lo0[1];
    wr_ent.v1   = bus.wr_lo1[1];
  end

  // Wrap once random has reached wired; wired >= TOP pins it at TOP.
  always_comb begin
    random_d = random_q - IDX_W'(1);
    if (bus.wired_we || random_q <= wired_q) begin
      random_d = TOP;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < NUM_ENTRIES; i++) begin
        ent_q[i] <= '0;
      end
      for (int k = 0; k < NUM_LKP; k++) begin
        lk_res_q[k] <= '0;
      end
      lk_rvld_q <= '0;
      wired_q   <= '0;
      random_q  <= TOP;
      wr_done_q <= 1'b0;
      p_done_q  <= 1'b0;
      p_miss_q  <= 1'b0;
      p_index_q <= '0;
      r_done_q  <= 1'b0;
      r_hi_q    <= '0;
      r_lo0_q   <= '0;
      r_lo1_q   <= '0;
    end else begin
      if (bus.wr_en) begin
        ent_q[wr_idx] <= wr_ent;
      end
      if (bus.wired_we) begin
        wired_q <= bus.wired_val;
      end
      random_q  <= random_d;
      wr_done_q <= bus.wr_en;
      lk_rvld_q <= bus.lk_req;
      for (int k = 0; k < NUM_LKP; k++) begin
        if (bus.lk_req[k]) begin
          lk_res_q[k] <= lk_res_d[k];
        end
      end
      p_done_q <= bus.p_req;
      if (bus.p_req) begin
        p_miss_q  <= ~p_hit_d;
        p_index_q <= p_idx_d;
      end
      r_done_q <= bus.r_req;
      if (bus.r_req) begin
        r_hi_q  <= {ent_q[bus.r_index].vpn2, 5'b0,
                    ent_q[bus.r_index].asid};
        r_lo0_q <= {6'b0, ent_q[bus.r_index].pfn0,
                    ent_q[bus.r_index].c0,
                    ent_q[bus.r_index].d0,
                    ent_q[bus.r_index].v0,
                    ent_q[bus.r_index].g};
        r_lo1_q <= {6'b0, ent_q[bus.r_index].pfn1,
                    ent_q[bus.r_index].c1,
                    ent_q[bus.r_index].d1,
                    ent_q[bus.r_index].v1,
                    ent_q[bus.r_index].g};
      end
    end
  end

  for (genvar k = 0; k < NUM_LKP; k++) begin : g_lk
    assign bus.lk_hit[k]          = lk_res_q[k][25];
    assign bus.lk_v[k]            = lk_res_q[k][24];
    assign bus.lk_d[k]            = lk_res_q[k][23];
    assign bus.lk_c[k*3 +: 3]     = lk_res_q[k][22:20];
    assign bus.lk_pfn[k*20 +: 20] = lk_res_q[k][19:0];
  end

  assign bus.lk_rvld    = lk_rvld_q;
  assign bus.wr_done    = wr_done_q;
  assign bus.random_val = random_q;
  assign bus.p_done     = p_done_q;
  assign bus.p_miss     = p_miss_q;
  assign bus.p_index    = p_index_q;
  assign bus.r_done     = r_done_q;
  assign bus.r_hi       = r_hi_q;
  assign bus.r_lo0      = r_lo0_q;
  assign bus.r_lo1      = r_lo1_q;
endmodule
